// File: rtl/adc_cmd_sequencer.sv
// UART-commanded SAR ADC sequencer: decodes single/averaged/scan/status
// command bytes, runs conversions and streams 16-bit results back as two bytes.
module adc_cmd_sequencer #(
    parameter int Width    = 10,
    parameter int Channels = 4,
    parameter int AvgLog2  = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_valid_i,
    output logic [7:0]       tx_data_o,
    output logic             tx_start_o,
    input  logic             tx_done_i,
    output logic             sar_start_o,
    input  logic             sar_done_i,
    input  logic [Width-1:0] sar_result_i,
    output logic [3:0]       ch_sel_o,
    output logic             busy_o,
    output logic             err_o,
    output logic             overrun_o
);
    localparam int AccW = Width + AvgLog2;
    localparam int CntW = AvgLog2 + 1;

    typedef enum logic [3:0] {
        IDLE, DECODE, SAR_START, SAR_WAIT, TX_HI, TX_HI_WAIT, TX_LO, TX_LO_WAIT, NEXT_CH
    } state_t;

    typedef enum logic [2:0] {K_SINGLE, K_AVG, K_SCAN, K_STATUS, K_ERROR} kind_t;

    state_t          state_q, state_d;
    kind_t           kind_q, kind_d;
    logic [7:0]      cmd_q;
    logic [3:0]      ch_q;
    logic [AccW-1:0] acc_q;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_target;
    logic [AccW-1:0] acc_shift;
    logic [15:0]     value;
    logic [7:0]      lo_byte;
    logic            more_ch;

    always_comb begin
        kind_d = K_ERROR;
        case (cmd_q[7:4])
            4'h1:    if (int'(cmd_q[3:0]) < Channels) kind_d = K_SINGLE;
            4'h2:    if (int'(cmd_q[3:0]) < Channels) kind_d = K_AVG;
            4'h3:    if (cmd_q[3:0] == 4'h0) kind_d = K_SCAN;
            4'h4:    if (cmd_q[3:0] == 4'h0) kind_d = K_STATUS;
            default: kind_d = K_ERROR;
        endcase
    end

    assign cnt_target = (kind_q == K_SINGLE) ? CntW'(1) : CntW'(1 << AvgLog2);
    assign acc_shift  = acc_q >> AvgLog2;
    assign value      = (kind_q == K_SINGLE) ? 16'(acc_q) : 16'(acc_shift);
    assign more_ch    = (kind_q == K_SCAN) && (int'(ch_q) < Channels - 1);
    assign ch_sel_o   = ch_q;

    always_comb begin
        case (kind_q)
            K_STATUS: lo_byte = 8'hA5;
            K_ERROR:  lo_byte = 8'hEE;
            default:  lo_byte = value[7:0];
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            kind_q  <= K_ERROR;
            cmd_q   <= '0;
            ch_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (rx_valid_i) cmd_q <= rx_data_i;
                DECODE: begin
                    kind_q <= kind_d;
                    // Scan starts at channel 0; replies without conversions park the mux at 0.
                    ch_q   <= (kind_d == K_SINGLE || kind_d == K_AVG) ? cmd_q[3:0] : 4'd0;
                    acc_q  <= '0;
                    cnt_q  <= '0;
                end
                SAR_WAIT: if (sar_done_i) begin
                    acc_q <= acc_q + AccW'(sar_result_i);
                    cnt_q <= cnt_q + CntW'(1);
                end
                NEXT_CH: begin
                    ch_q  <= ch_q + 4'd1;
                    acc_q <= '0;
                    cnt_q <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        sar_start_o = 1'b0;
        tx_start_o  = 1'b0;
        tx_data_o   = '0;
        err_o       = 1'b0;
        busy_o      = (state_q != IDLE);
        overrun_o   = rx_valid_i && (state_q != IDLE);
        case (state_q)
            IDLE:      if (rx_valid_i) state_d = DECODE;
            DECODE: begin
                err_o   = (kind_d == K_ERROR);
                state_d = (kind_d == K_SINGLE || kind_d == K_AVG || kind_d == K_SCAN)
                          ? SAR_START : TX_LO;
            end
            SAR_START: begin
                sar_start_o = 1'b1;
                state_d     = SAR_WAIT;
            end
            SAR_WAIT: if (sar_done_i) begin
                state_d = (cnt_q + CntW'(1) == cnt_target) ? TX_HI : SAR_START;
            end
            TX_HI: begin
                tx_start_o = 1'b1;
                tx_data_o  = value[15:8];
                state_d    = TX_HI_WAIT;
            end
            TX_HI_WAIT: begin
                tx_data_o = value[15:8];
                if (tx_done_i) state_d = TX_LO;
            end
            TX_LO: begin
                tx_start_o = 1'b1;
                tx_data_o  = lo_byte;
                state_d    = TX_LO_WAIT;
            end
            TX_LO_WAIT: begin
                tx_data_o = lo_byte;
                if (tx_done_i) state_d = more_ch ? NEXT_CH : IDLE;
            end
            NEXT_CH:   state_d = SAR_START;
            default:   state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_adc_cmd_sequencer.sv
// Bench for adc_cmd_sequencer: directed vector table, hand-written reset and
// overrun sequences, then randomized commands against a reference model.
module tb_adc_cmd_sequencer;
    localparam int W  = 10;
    localparam int CH = 4;
    localparam int AL = 2;
    localparam int N  = 1 << AL;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic [7:0]   rx_data_i = '0;
    logic         rx_valid_i = 1'b0;
    logic [7:0]   tx_data_o;
    logic         tx_start_o;
    logic         tx_done_i = 1'b0;
    logic         sar_start_o;
    logic         sar_done_i = 1'b0;
    logic [W-1:0] sar_result_i = '0;
    logic [3:0]   ch_sel_o;
    logic         busy_o, err_o, overrun_o;

    adc_cmd_sequencer #(.Width(W), .Channels(CH), .AvgLog2(AL)) dut (
        .clk_i(clk), .rst_i(rst_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
        .tx_data_o(tx_data_o), .tx_start_o(tx_start_o), .tx_done_i(tx_done_i),
        .sar_start_o(sar_start_o), .sar_done_i(sar_done_i), .sar_result_i(sar_result_i),
        .ch_sel_o(ch_sel_o), .busy_o(busy_o), .err_o(err_o), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned failures = 0;

    logic [7:0]   obs_bytes[$];
    logic [3:0]   obs_ch[$];
    logic [W-1:0] sar_q[$];
    int unsigned  n_err, n_ovr, hold_bad, ch_bad;
    int           lat_start, lat_tx;
    bit           timed_out;

    logic [7:0]   exp_bytes[$];
    logic [3:0]   exp_ch[$];
    int unsigned  exp_err;
    logic [W-1:0] rres[CH*N];

    typedef struct {
        logic [7:0]  cmd;
        logic [9:0]  r0, r1, r2, r3;
        bit          rep;
        int unsigned nbytes;
        logic [63:0] bytes;
        int unsigned nstarts;
        int unsigned nerr;
        int unsigned ch_base;
        int unsigned ch_div;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Sends one command and plays the SAR and UART roles until the DUT idles.
    task automatic service(input logic [7:0] cmd, input int unsigned exp_nbytes,
                           input int unsigned ovr_mode, input bit stray);
        int         sar_wait = -1;
        int         tx_wait = -1;
        bit         tx_act = 0;
        bit         tx_done_now;
        bit         injected = 0;
        logic [7:0] cur_tx = '0;
        logic [3:0] cur_ch = '0;
        int         last_done = -1;
        obs_bytes.delete(); obs_ch.delete();
        n_err = 0; n_ovr = 0; hold_bad = 0; ch_bad = 0;
        lat_start = -1; lat_tx = -1; timed_out = 1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            rx_valid_i = 0; sar_done_i = 0; tx_done_i = 0; tx_done_now = 0;
            if (cyc == 0) begin rx_data_i = cmd; rx_valid_i = 1; end
            if (stray && cyc == 1) begin sar_done_i = 1; sar_result_i = '1; tx_done_i = 1; end
            if (sar_wait > 0) begin
                sar_wait--;
                if (sar_wait == 0) begin
                    sar_done_i = 1;
                    sar_result_i = (sar_q.size() > 0) ? sar_q.pop_front() : '0;
                    last_done = cyc;
                    sar_wait = -1;
                end
            end
            if (tx_wait > 0) begin
                tx_wait--;
                if (tx_wait == 0) begin
                    tx_done_i = 1; tx_done_now = 1; tx_wait = -1;
                    if (ovr_mode == 2 && obs_bytes.size() == exp_nbytes) begin
                        rx_valid_i = 1; rx_data_i = 8'h12;
                    end
                end else if (ovr_mode == 1 && !injected) begin
                    rx_valid_i = 1; rx_data_i = 8'h12; injected = 1;
                end
            end
            #1;
            if (err_o) n_err++;
            if (overrun_o) n_ovr++;
            if (last_done == cyc && ch_sel_o !== cur_ch) ch_bad++;
            if (tx_act && !tx_start_o && tx_data_o !== cur_tx) hold_bad++;
            if (tx_done_now) tx_act = 0;
            if (sar_start_o) begin
                obs_ch.push_back(ch_sel_o);
                cur_ch = ch_sel_o;
                sar_wait = $urandom_range(1, 4);
                if (lat_start < 0) lat_start = cyc;
            end
            if (tx_start_o) begin
                obs_bytes.push_back(tx_data_o);
                cur_tx = tx_data_o;
                tx_act = 1;
                tx_wait = $urandom_range(2, 5);
                if (lat_tx < 0 && last_done >= 0) lat_tx = cyc - last_done;
            end
            if (cyc >= 1 && !busy_o && sar_wait < 0 && tx_wait < 0) begin
                timed_out = 0;
                break;
            end
        end
        sar_q.delete();
    endtask

    // Reference: derives replies directly from the command rules and the result list.
    task automatic model(input logic [7:0] cmd);
        int unsigned op, c, sum;
        logic [15:0] v;
        op = cmd[7:4]; c = cmd[3:0];
        exp_bytes.delete(); exp_ch.delete(); exp_err = 0;
        if (op == 1 && c < CH) begin
            v = 16'(rres[0]);
            exp_ch.push_back(4'(c));
            exp_bytes.push_back(v[15:8]); exp_bytes.push_back(v[7:0]);
        end else if ((op == 2 && c < CH) || (op == 3 && c == 0)) begin
            for (int ch = 0; ch < ((op == 3) ? CH : 1); ch++) begin
                sum = 0;
                for (int k = 0; k < N; k++) begin
                    sum += rres[ch*N + k];
                    exp_ch.push_back((op == 3) ? 4'(ch) : 4'(c));
                end
                v = 16'(sum / N);
                exp_bytes.push_back(v[15:8]); exp_bytes.push_back(v[7:0]);
            end
        end else if (op == 4 && c == 0) begin
            exp_bytes.push_back(8'hA5);
        end else begin
            exp_bytes.push_back(8'hEE);
            exp_err = 1;
        end
    endtask

    initial begin
        vecs[0] = '{8'h12, 10'h2A7, 10'h0,   10'h0,   10'h0,   1'b0, 2, 64'h02A7_0000_0000_0000, 1,  0, 2, 1};
        vecs[1] = '{8'h21, 10'h100, 10'h101, 10'h102, 10'h103, 1'b0, 2, 64'h0101_0000_0000_0000, 4,  0, 1, 4};
        vecs[2] = '{8'h30, 10'h000, 10'h3FF, 10'h155, 10'h2AA, 1'b1, 8, 64'h0000_03FF_0155_02AA, 16, 0, 0, 4};
        vecs[3] = '{8'h17, 10'h0,   10'h0,   10'h0,   10'h0,   1'b0, 1, 64'hEE00_0000_0000_0000, 0,  1, 0, 1};
        vecs[4] = '{8'h90, 10'h0,   10'h0,   10'h0,   10'h0,   1'b0, 1, 64'hEE00_0000_0000_0000, 0,  1, 0, 1};
        vecs[5] = '{8'h31, 10'h0,   10'h0,   10'h0,   10'h0,   1'b0, 1, 64'hEE00_0000_0000_0000, 0,  1, 0, 1};
        vecs[6] = '{8'h40, 10'h0,   10'h0,   10'h0,   10'h0,   1'b0, 1, 64'hA500_0000_0000_0000, 0,  0, 0, 1};
        vecs[7] = '{8'h41, 10'h0,   10'h0,   10'h0,   10'h0,   1'b0, 1, 64'hEE00_0000_0000_0000, 0,  1, 0, 1};
        vecs[8] = '{8'h13, 10'h3FF, 10'h0,   10'h0,   10'h0,   1'b0, 2, 64'h03FF_0000_0000_0000, 1,  0, 3, 1};
        vecs[9] = '{8'h23, 10'h000, 10'h000, 10'h000, 10'h003, 1'b0, 2, 64'h0000_0000_0000_0000, 4,  0, 3, 4};

        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", 32'(busy_o), 0);
        check("rst_sar_start", 32'(sar_start_o), 0);
        check("rst_tx_start", 32'(tx_start_o), 0);
        check("rst_tx_data", 32'(tx_data_o), 0);
        check("rst_ch_sel", 32'(ch_sel_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_overrun", 32'(overrun_o), 0);
        rst_i = 0;

        foreach (vecs[vi]) begin
            logic [9:0] rr[4];
            rr = '{vecs[vi].r0, vecs[vi].r1, vecs[vi].r2, vecs[vi].r3};
            for (int k = 0; k < 4; k++)
                for (int j = 0; j < (vecs[vi].rep ? N : 1); j++) sar_q.push_back(rr[k]);
            service(vecs[vi].cmd, vecs[vi].nbytes, 0, 0);
            check($sformatf("v%0d_timeout", vi), 32'(timed_out), 0);
            check($sformatf("v%0d_nbytes", vi), obs_bytes.size(), vecs[vi].nbytes);
            for (int i = 0; i < int'(vecs[vi].nbytes) && i < obs_bytes.size(); i++)
                check($sformatf("v%0d_byte%0d", vi, i), 32'(obs_bytes[i]), 32'(vecs[vi].bytes[63-8*i -: 8]));
            check($sformatf("v%0d_nstarts", vi), obs_ch.size(), vecs[vi].nstarts);
            for (int k = 0; k < obs_ch.size(); k++)
                check($sformatf("v%0d_ch%0d", vi, k), 32'(obs_ch[k]), vecs[vi].ch_base + k / vecs[vi].ch_div);
            check($sformatf("v%0d_err", vi), n_err, vecs[vi].nerr);
            check($sformatf("v%0d_hold", vi), hold_bad + ch_bad, 0);
            if (vecs[vi].nstarts > 0) begin
                check($sformatf("v%0d_lat_start", vi), 32'(lat_start), 2);
                check($sformatf("v%0d_lat_tx", vi), 32'(lat_tx), 1);
            end
        end

        // Overrun while waiting for the status byte, then on the final tx_done cycle.
        for (int m = 1; m <= 2; m++) begin
            service(8'h40, 1, m, 0);
            check($sformatf("ovr%0d_timeout", m), 32'(timed_out), 0);
            check($sformatf("ovr%0d_pulses", m), n_ovr, 1);
            check($sformatf("ovr%0d_nbytes", m), obs_bytes.size(), 1);
            if (obs_bytes.size() > 0) check($sformatf("ovr%0d_byte", m), 32'(obs_bytes[0]), 32'h A5);
        end

        // Reset while a conversion is outstanding.
        begin
            int unsigned stray_act = 0;
            bit seen = 0;
            @(negedge clk); rx_data_i = 8'h21; rx_valid_i = 1;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk); rx_valid_i = 0; #1;
                seen = sar_start_o;
            end
            check("rstmid_started", 32'(seen), 1);
            @(negedge clk); rst_i = 1;
            @(negedge clk); rst_i = 0; sar_done_i = 1; sar_result_i = 10'h3FF;
            #1;
            check("rstmid_busy", 32'(busy_o), 0);
            check("rstmid_ch_sel", 32'(ch_sel_o), 0);
            check("rstmid_starts", 32'({sar_start_o, tx_start_o}), 0);
            check("rstmid_tx_data", 32'(tx_data_o), 0);
            check("rstmid_flags", 32'({err_o, overrun_o}), 0);
            for (int i = 0; i < 6; i++) begin
                @(negedge clk); sar_done_i = 0; tx_done_i = (i == 2); #1;
                if (sar_start_o || tx_start_o || busy_o) stray_act++;
            end
            tx_done_i = 0;
            check("rstmid_quiet", stray_act, 0);
            service(8'h40, 1, 0, 0);
            check("rstmid_status_n", obs_bytes.size(), 1);
            if (obs_bytes.size() > 0) check("rstmid_status", 32'(obs_bytes[0]), 32'h A5);
        end

        for (int it = 0; it < 40; it++) begin
            int unsigned op, lo, ovr;
            bit stray;
            logic [7:0] cmd;
            op = ($urandom_range(0, 3) != 0) ? $urandom_range(1, 4) : $urandom_range(0, 15);
            if (op == 3 || op == 4) lo = ($urandom_range(0, 3) != 0) ? 0 : $urandom_range(1, 15);
            else lo = $urandom_range(0, 5);
            cmd = {4'(op), 4'(lo)};
            ovr = $urandom_range(0, 2);
            stray = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < CH*N; k++) begin
                rres[k] = W'($urandom_range(0, (1 << W) - 1));
                sar_q.push_back(rres[k]);
            end
            model(cmd);
            service(cmd, exp_bytes.size(), ovr, stray);
            check($sformatf("r%0d_timeout", it), 32'(timed_out), 0);
            check($sformatf("r%0d_nbytes_cmd%0h", it, cmd), obs_bytes.size(), exp_bytes.size());
            for (int i = 0; i < exp_bytes.size() && i < obs_bytes.size(); i++)
                check($sformatf("r%0d_byte%0d_cmd%0h", it, i, cmd), 32'(obs_bytes[i]), 32'(exp_bytes[i]));
            check($sformatf("r%0d_nstarts", it), obs_ch.size(), exp_ch.size());
            for (int k = 0; k < exp_ch.size() && k < obs_ch.size(); k++)
                check($sformatf("r%0d_ch%0d", it, k), 32'(obs_ch[k]), 32'(exp_ch[k]));
            check($sformatf("r%0d_err", it), n_err, exp_err);
            check($sformatf("r%0d_ovr", it), n_ovr, (ovr != 0) ? 1 : 0);
            check($sformatf("r%0d_hold", it), hold_bad + ch_bad, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
